mem_access_unit: RTL and testbench

Memory-stage responder for the control word produced by the main decoder. Consumes `MemRead`/`MemWrite`/`MemtoReg`/`RegWrite` plus the ALU result and store data. Runs a req/ack transaction to data memory for loads and stores, stalls the pipeline while the transaction is outstanding, and presents a registered writeback beat to the register file. Sits between the EX/MEM pipeline register and the register-file write port.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/lsu_align.sv | 74 +++++++
 rtl/mem_access_unit.sv | 179 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants and types for the memory-access stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // Load/store size and sign encodings carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables and replication, access legality
// checking, and load byte/half extraction with sign or zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            err_o,
    input  logic [2:0]      ld_funct3_i,
    input  logic [1:0]      ld_offset_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] ld_data_o
);

    logic       w_illegal;
    logic       w_misaligned;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    // Request side: lanes for stores, legality for both directions
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = store_data_i;
        if (mem_write_i) begin
            case (funct3_i)
                F3_B: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{store_data_i[7:0]}};
                end
                F3_H: begin
                    be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                    wdata_o      = {2{store_data_i[15:0]}};
                    w_misaligned = addr_lo_i[0];
                end
                F3_W:    w_misaligned = |addr_lo_i;
                default: w_illegal    = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B, F3_BU: w_misaligned = 1'b0;
                F3_H, F3_HU: w_misaligned = addr_lo_i[0];
                F3_W:        w_misaligned = |addr_lo_i;
                default:     w_illegal    = 1'b1;
            endcase
        end
        err_o = (mem_read_i & mem_write_i) | w_illegal | w_misaligned;
    end

    // Response side: pick the addressed byte/half and extend it
    always_comb begin
        case (ld_offset_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = ld_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_BU:   ld_data_o = {{(XLEN-8){1'b0}}, w_byte};
            F3_H:    ld_data_o = {{(XLEN-16){w_half[15]}}, w_half};
            F3_HU:   ld_data_o = {{(XLEN-16){1'b0}}, w_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage responder: runs one req/ack data-memory transaction per load or
// store, stalls upstream while it is outstanding, and emits a registered
// writeback beat for every valid instruction.
module mem_access_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            reg_write_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            stall_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            err_o
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_next;

    // Latched request
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_be;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic [2:0]      r_funct3;
    logic [1:0]      r_offset;
    logic            r_ld_we;

    // Writeback beat
    logic            r_wb_valid;
    logic            r_wb_we;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            r_err;

    logic            w_is_mem;
    logic            w_bad;
    logic            w_idle_valid;
    logic            w_accept;
    logic            w_done;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ld_data;

    assign w_is_mem     = mem_read_i | mem_write_i;
    assign w_idle_valid = (r_state == StIdle) & valid_i;
    assign w_accept     = w_idle_valid & w_is_mem & ~w_bad;
    assign w_done       = (r_state == StBusy) & dmem_ack_i;

    lsu_align u_align (
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_lo_i    (alu_result_i[1:0]),
        .store_data_i (store_data_i),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .err_o        (w_bad),
        .ld_funct3_i  (r_funct3),
        .ld_offset_i  (r_offset),
        .rdata_i      (dmem_rdata_i),
        .ld_data_o    (w_ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: one outstanding request, always returning through IDLE
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = StBusy;
            StBusy: if (dmem_ack_i) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs: request follows BUSY so an async reset drops it at once
    always_comb begin
        stall_o    = 1'b0;
        dmem_req_o = 1'b0;
        unique case (r_state)
            StIdle: stall_o = w_accept;
            StBusy: begin
                stall_o    = ~dmem_ack_i;
                dmem_req_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture; held stable for the whole transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wdata  <= '0;
            r_rd     <= '0;
            r_funct3 <= '0;
            r_offset <= '0;
            r_ld_we  <= 1'b0;
        end else if (w_accept) begin
            r_we     <= mem_write_i;
            r_addr   <= {alu_result_i[XLEN-1:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_rd     <= rd_i;
            r_funct3 <= funct3_i;
            r_offset <= alu_result_i[1:0];
            r_ld_we  <= reg_write_i & mem_to_reg_i;
        end
    end

    // Writeback beat: single-cycle pulse after a non-mem op, an error or an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_err      <= 1'b0;
            if (w_idle_valid && !w_is_mem) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= reg_write_i;
                r_wb_rd    <= rd_i;
                r_wb_data  <= alu_result_i;
            end else if (w_idle_valid && w_bad) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= rd_i;
                r_wb_data  <= '0;
                r_err      <= 1'b1;
            end else if (w_done) begin
                r_wb_valid <= 1'b1;
                r_wb_we    <= ~r_we & r_ld_we;
                r_wb_rd    <= r_rd;
                r_wb_data  <= r_we ? '0 : w_ld_data;
            end
        end
    end

    assign dmem_we_o    = r_we;
    assign dmem_addr_o  = r_addr;
    assign dmem_be_o    = r_be;
    assign dmem_wdata_o = r_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_we_o      = r_wb_we;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign err_o        = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed instructions, a bench-driven
// memory responder, and a scoreboard of expected writeback beats.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        mem_read_i;
    logic        mem_write_i;
    logic        mem_to_reg_i;
    logic        reg_write_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_result_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .mem_to_reg_i (mem_to_reg_i),
        .reg_write_i  (reg_write_i),
        .funct3_i     (funct3_i),
        .rd_i         (rd_i),
        .alu_result_i (alu_result_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Writeback monitor: every beat must match the oldest expected entry, on time
    always @(negedge clk) begin
        sb_t e;
        if (wb_valid_o) begin
            if (sb_q.size() == 0) begin
                check_eq("wb_unexpected", wb_valid_o, 0);
            end else begin
                e = sb_q.pop_front();
                check_eq("wb_cycle", cyc, e.cyc);
                check_eq("wb_we", wb_we_o, e.we);
                check_eq("wb_rd", wb_rd_o, e.rd);
                check_eq("wb_err", err_o, e.err);
                if (e.chk_data) check_eq("wb_data", wb_data_o, e.data);
            end
        end else if (err_o) begin
            check_eq("err_without_wb", err_o, 0);
        end
    end

    // Drive one instruction; for legal memory ops act as memory, acking after 'waits' cycles
    task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [2:0] f3, input logic [4:0] rdx, input logic [31:0] alu,
                         input logic [31:0] sd, input int waits, input logic [31:0] rdata,
                         input logic bad, input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] edata);
        sb_t  e;
        int   stalls;
        logic go_mem;
        go_mem       = (rd | wr) & ~bad;
        valid_i      = 1'b1;
        mem_read_i   = rd;
        mem_write_i  = wr;
        mem_to_reg_i = m2r;
        reg_write_i  = rw;
        funct3_i     = f3;
        rd_i         = rdx;
        alu_result_i = alu;
        store_data_i = sd;
        @(negedge clk);
        check_eq("stall_accept", stall_o, go_mem);
        if (!go_mem) check_eq("no_req", dmem_req_o, 0);
        stalls = int'(stall_o);
        @(posedge clk); #1;
        if (go_mem) begin
            for (int w = 0; w <= waits; w++) begin
                dmem_ack_i   = (w == waits);
                dmem_rdata_i = (w == waits) ? rdata : 32'hDEAD_BEEF;
                @(negedge clk);
                check_eq("req_high", dmem_req_o, 1);
                check_eq("req_addr", dmem_addr_o, {alu[31:2], 2'b00});
                check_eq("req_we", dmem_we_o, wr);
                check_eq("req_be", dmem_be_o, ebe);
                if (wr) check_eq("req_wdata", dmem_wdata_o, ewd);
                check_eq("stall_busy", stall_o, !dmem_ack_i);
                stalls += int'(stall_o);
                @(posedge clk); #1;
            end
            dmem_ack_i = 1'b0;
            check_eq("stall_cycles", stalls, waits + 1);
        end
        e.we       = bad ? 1'b0 : (wr ? 1'b0 : (rd ? (rw & m2r) : rw));
        e.rd       = rdx;
        e.data     = edata;
        e.chk_data = !bad && !wr;
        e.err      = bad;
        e.cyc      = cyc;
        sb_q.push_back(e);
        valid_i = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        valid_i      = 1'b0;
        mem_read_i   = 1'b0;
        mem_write_i  = 1'b0;
        mem_to_reg_i = 1'b0;
        reg_write_i  = 1'b0;
        funct3_i     = 3'b000;
        rd_i         = 5'd0;
        alu_result_i = 32'h0;
        store_data_i = 32'h0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;

        repeat (2) @(negedge clk);
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_req", dmem_req_o, 0);
        check_eq("rst_wb_valid", wb_valid_o, 0);
        check_eq("rst_err", err_o, 0);
        check_eq("rst_addr", dmem_addr_o, 0);
        check_eq("rst_be", dmem_be_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-memory ops
        issue(0, 0, 0, 1, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0,
              32'h0000_1234);
        issue(0, 0, 0, 0, 3'b000, 5'd7, 32'hCAFE_0001, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0,
              32'hCAFE_0001);
        // lb / lbu at 0x103 with three wait cycles
        issue(1, 0, 1, 1, 3'b000, 5'd8, 32'h0000_0103, 32'h0, 3, 32'h80FF_FFFF, 0, 4'hF,
              32'h0, 32'hFFFF_FF80);
        issue(1, 0, 1, 1, 3'b100, 5'd9, 32'h0000_0103, 32'h0, 3, 32'h80FF_FFFF, 0, 4'hF,
              32'h0, 32'h0000_0080);
        // sh at 0x202, sb at 0x001
        issue(0, 1, 0, 0, 3'b001, 5'd0, 32'h0000_0202, 32'h0000_BEEF, 2, 32'h0, 0, 4'hC,
              32'hBEEF_BEEF, 32'h0);
        issue(0, 1, 0, 0, 3'b000, 5'd0, 32'h0000_0001, 32'h1234_5678, 1, 32'h0, 0, 4'h2,
              32'h7878_7878, 32'h0);
        // lh / lhu upper half, lw aligned
        issue(1, 0, 1, 1, 3'b001, 5'd10, 32'h0000_0102, 32'h0, 1, 32'h8001_0000, 0, 4'hF,
              32'h0, 32'hFFFF_8001);
        issue(1, 0, 1, 1, 3'b101, 5'd11, 32'h0000_0102, 32'h0, 0, 32'h8001_0000, 0, 4'hF,
              32'h0, 32'h0000_8001);
        issue(1, 0, 1, 1, 3'b010, 5'd12, 32'h0000_0500, 32'h0, 2, 32'h1357_9BDF, 0, 4'hF,
              32'h0, 32'h1357_9BDF);
        // Load without mem_to_reg: beat with we=0
        issue(1, 0, 0, 1, 3'b010, 5'd13, 32'h0000_0504, 32'h0, 0, 32'h1111_2222, 0, 4'hF,
              32'h0, 32'h1111_2222);
        // Error cases: misaligned lw, misaligned sh, read+write, illegal funct3
        issue(1, 0, 1, 1, 3'b010, 5'd14, 32'h0000_0101, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        issue(0, 1, 0, 0, 3'b001, 5'd0, 32'h0000_0203, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        issue(1, 1, 1, 1, 3'b010, 5'd15, 32'h0000_0200, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        issue(1, 0, 1, 1, 3'b011, 5'd16, 32'h0000_0200, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);
        issue(0, 1, 0, 0, 3'b100, 5'd0, 32'h0000_0200, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0, 32'h0);

        // Ack while idle must be ignored
        @(posedge clk); #1;
        dmem_ack_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("idle_ack_req", dmem_req_o, 0);
            @(posedge clk); #1;
        end
        dmem_ack_i = 1'b0;
        @(negedge clk);
        check_eq("idle_ack_wb", wb_valid_o, 0);
        @(posedge clk); #1;

        // sw interrupted by reset; late ack after release produces nothing
        valid_i      = 1'b1;
        mem_write_i  = 1'b1;
        funct3_i     = 3'b010;
        alu_result_i = 32'h0000_0300;
        store_data_i = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rst_mid_req_before", dmem_req_o, 1);
        @(posedge clk); #1;
        valid_i     = 1'b0;
        mem_write_i = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_eq("rst_mid_req_drop", dmem_req_o, 0);
        check_eq("rst_mid_stall", stall_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_ack_i = 1'b1;
        @(negedge clk);
        check_eq("late_ack_req", dmem_req_o, 0);
        @(posedge clk); #1;
        dmem_ack_i = 1'b0;
        @(negedge clk);
        check_eq("late_ack_wb", wb_valid_o, 0);
        @(posedge clk); #1;

        // Back-to-back lw with immediate ack, then an add
        issue(1, 0, 1, 1, 3'b010, 5'd20, 32'h0000_0400, 32'h0, 0, 32'hAAAA_0001, 0, 4'hF,
              32'h0, 32'hAAAA_0001);
        issue(1, 0, 1, 1, 3'b010, 5'd21, 32'h0000_0404, 32'h0, 0, 32'hBBBB_0002, 0, 4'hF,
              32'h0, 32'hBBBB_0002);
        issue(0, 0, 0, 1, 3'b000, 5'd22, 32'h0000_00AD, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0,
              32'h0000_00AD);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
